cla16_lfsr_opgen: RTL
=====================

// Module: cla16_lfsr_opgen
// PURPOSE
//  Pseudo-random operand source that sits directly upstream of bit16_cla.
//  On a start pulse it emits NVEC operand sets (ain, bin, cin) from two
//  16-bit Fibonacci LFSRs, one set per accepted cycle, with a vld/hold stall.
//  Drives bit16_cla for self-checking regression and for on-chip BIST.
// PARAMETERS
//  SEED_A  16'hACE1  initial state of operand-A LFSR (0 is replaced by 16'h0001)
//  SEED_B  16'h1D2B  initial state of operand-B LFSR (0 is replaced by 16'h0001)
//  CNT_W   8         width of nvec and of the internal vector counter
// PORTS
//  clk    in   1      rising-edge clock, single clock domain
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      run request, sampled only in IDLE
//  nvec   in   CNT_W  number of vectors to emit, sampled with start
//  hold   in   1      downstream stall; current vector is not consumed
//  ain    out  16     operand A to bit16_cla
//  bin    out  16     operand B to bit16_cla
//  cin    out  1      carry-in to bit16_cla, = ain[0]^bin[0]
//  vld    out  1      ain/bin/cin are a valid vector
//  busy   out  1      high in RUN
//  done   out  1      one-cycle pulse after the last vector is consumed
// BEHAVIOUR
//  - All outputs registered. Reset (async, rst_n=0): state=IDLE, ain=bin=0,
//    cin=vld=busy=done=0, LFSR_A=SEED_A, LFSR_B=SEED_B, counter=0.
//  - LFSR step: q <= {q[14:0], q[15]^q[13]^q[12]^q[10]} (x^16+x^14+x^13+x^11+1).
//    Period 65535; all-zero state is never reached.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE: vld=0. If start=1 and nvec!=0, latch nvec, load seeds, go to RUN.
//    In the next cycle vld=1, ain=SEED_A, bin=SEED_B, cin=SEED_A[0]^SEED_B[0].
//    If start=1 and nvec==0, go to DONE; no vector is emitted.
//  - RUN: a vector is consumed on any cycle with vld=1 and hold=0.
//    On consume with counter<nvec-1: both LFSRs step, ain/bin/cin update, and
//    the counter increments. Latency is one vector per clock with no bubbles.
//    On consume with counter==nvec-1: go to DONE; vld=0 next cycle.
//    When hold=1, ain/bin/cin/vld and both LFSRs stay frozen for any duration.
//  - DONE: done=1 for exactly one cycle, busy=0, vld=0; then IDLE.
//    The counter clears. LFSRs reload seeds on the next start, so every run
//    replays the same sequence.
//  - start is ignored in RUN and DONE (no restart, no queueing).
//  - nvec changes after start have no effect; the latched value is used.
//  - nvec=2^CNT_W-1 is the maximum run; the counter never wraps within a run.
//  - rst_n low mid-run aborts immediately to reset values. done is not pulsed.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle -> all outputs 0 at once, before any clk edge.
//  2 start, nvec=3, hold=0 -> vld high 3 cycles, as follows:
//    ain 0xACE1,0x59C3,0xB387; bin 0x1D2B,0x3A56,0x74AC; cin 0,1,1.
//    done=1 in the cycle after the last vector; vld=0 in that cycle.
//  3 As 2, with hold=1 for 2 cycles while ain=0x59C3 -> ain/bin hold 0x59C3/0x3A56.
//    vld is high for 5 cycles total, and the same 3 vectors are emitted in order.
//  4 start with nvec=0 -> done pulses, vld never rises.
//    A start pulse during RUN -> ignored; the vector count is unchanged.
//  5 rst_n=0 after vector 2 of an nvec=10 run -> outputs clear, no done.
//    A new start replays from ain=0xACE1.
//  6 nvec=255 into bit16_cla -> every {cout,sum} == ain+bin+cin against the
//    bench model; exactly 255 vld cycles; ain and bin never 0.

Source files
------------

// File: rtl/cla16_lfsr_opgen.sv
// Pseudo-random operand generator for bit16_cla: two 16-bit Fibonacci LFSRs
// emit a fixed-length, replayable run of (ain, bin, cin) vectors under a vld/hold handshake.
module cla16_lfsr_opgen #(
  parameter logic [15:0] SEED_A = 16'hACE1,
  parameter logic [15:0] SEED_B = 16'h1D2B,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] nvec,
  input  logic             hold,
  output logic [15:0]      ain,
  output logic [15:0]      bin,
  output logic             cin,
  output logic             vld,
  output logic             busy,
  output logic             done
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SA = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
  localparam logic [15:0] SB = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [15:0]      lfsr_a, lfsr_a_d, lfsr_b, lfsr_b_d;
  logic [CNT_W-1:0] cnt, cnt_d, nvec_q, nvec_d;
  logic [15:0]      ain_d, bin_d;
  logic             cin_d, vld_d, busy_d, done_d;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lfsr_a <= SA;
      lfsr_b <= SB;
      cnt    <= '0;
      nvec_q <= '0;
      ain    <= '0;
      bin    <= '0;
      cin    <= 1'b0;
      vld    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      lfsr_a <= lfsr_a_d;
      lfsr_b <= lfsr_b_d;
      cnt    <= cnt_d;
      nvec_q <= nvec_d;
      ain    <= ain_d;
      bin    <= bin_d;
      cin    <= cin_d;
      vld    <= vld_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    lfsr_a_d = lfsr_a;
    lfsr_b_d = lfsr_b;
    cnt_d    = cnt;
    nvec_d   = nvec_q;
    ain_d    = ain;
    bin_d    = bin;
    cin_d    = cin;
    vld_d    = vld;
    unique case (state)
      IDLE: begin
        vld_d = 1'b0;
        if (start) begin
          if (nvec != '0) begin
            state_d  = RUN;
            nvec_d   = nvec;
            cnt_d    = '0;
            lfsr_a_d = SA;
            lfsr_b_d = SB;
            ain_d    = SA;
            bin_d    = SB;
            cin_d    = SA[0] ^ SB[0];
            vld_d    = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (vld && !hold) begin
          if (cnt == nvec_q - ONE) begin
            state_d = DONE;
            vld_d   = 1'b0;
          end else begin
            lfsr_a_d = lfsr_step(lfsr_a);
            lfsr_b_d = lfsr_step(lfsr_b);
            ain_d    = lfsr_a_d;
            bin_d    = lfsr_b_d;
            cin_d    = lfsr_a_d[0] ^ lfsr_b_d[0];
            cnt_d    = cnt + ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        vld_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered copies of the next state.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

endmodule
